// File: rtl/wr_decoder_pipe_if.sv
// Write-port bundle between writeback (master) and the registered
// write-enable decoder (slave) that feeds the register-file array.
interface wr_decoder_pipe_if #(
  parameter int ADDR_W = 5,
  parameter int NPORTS = 2
);
  localparam int NREGS = 1 << ADDR_W;

  logic                     enable;
  logic [NPORTS-1:0]        port_valid;
  logic [NPORTS*ADDR_W-1:0] port_addr;
  logic                     clr_dirty;
  logic [NREGS-1:0]         we_out;
  logic [NPORTS-1:0]        port_grant;
  logic                     conflict;
  logic [NREGS-1:0]         dirty;
  logic [15:0]              wr_cnt;

  modport master (
    output enable, port_valid, port_addr, clr_dirty,
    input  we_out, port_grant, conflict, dirty, wr_cnt
  );

  modport slave (
    input  enable, port_valid, port_addr, clr_dirty,
    output we_out, port_grant, conflict, dirty, wr_cnt
  );
endinterface

// File: rtl/wr_decoder_pipe.sv
// Registered multi-port register-file write-enable decoder: highest port wins
// same-address collisions, the zero register is masked, and writes are tracked.
module wr_decoder_pipe #(
  parameter int ADDR_W   = 5,
  parameter int NPORTS   = 2,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_IDX = 31
) (
  input  logic            clk,
  input  logic            reset_n,
  wr_decoder_pipe_if.slave bus
);
  localparam int NREGS = 1 << ADDR_W;
  localparam int PCW   = $clog2(NPORTS + 1);

  logic [ADDR_W-1:0] addr [NPORTS];
  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] grant_d;
  logic [NREGS-1:0]  we_d;
  logic              conflict_d;
  logic [PCW-1:0]    pop;
  logic [16:0]       sum;
  logic [NREGS-1:0]  dirty_d;
  logic [15:0]       cnt_d;

  logic [NREGS-1:0]  we_q;
  logic [NPORTS-1:0] grant_q;
  logic              conflict_q;
  logic [NREGS-1:0]  dirty_q;
  logic [15:0]       cnt_q;

  always_comb begin
    req = '0;
    for (int i = 0; i < NPORTS; i++) begin
      addr[i] = bus.port_addr[i*ADDR_W +: ADDR_W];
      req[i]  = bus.enable & bus.port_valid[i]
              & ~((ZERO_EN != 0) && (addr[i] == ADDR_W'(ZERO_IDX)));
    end
  end

  // A request is granted only if no higher-index port targets the same register.
  always_comb begin
    grant_d    = '0;
    we_d       = '0;
    conflict_d = 1'b0;
    pop        = '0;
    for (int i = 0; i < NPORTS; i++) begin
      grant_d[i] = req[i];
      for (int j = i + 1; j < NPORTS; j++) begin
        if (req[j] && (addr[j] == addr[i])) begin
          grant_d[i] = 1'b0;
        end
      end
      if (grant_d[i]) begin
        we_d[addr[i]] = 1'b1;
        pop           = pop + PCW'(1);
      end else if (req[i]) begin
        conflict_d = 1'b1;
      end
    end
  end

  // A write landing in the clearing cycle is kept rather than wiped by the clear.
  always_comb begin
    sum = {1'b0, cnt_q} + {{(17-PCW){1'b0}}, pop};
    if (bus.clr_dirty) begin
      dirty_d = we_d;
      cnt_d   = 16'(pop);
    end else begin
      dirty_d = dirty_q | we_d;
      cnt_d   = sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q       <= '0;
      grant_q    <= '0;
      conflict_q <= 1'b0;
      dirty_q    <= '0;
      cnt_q      <= '0;
    end else begin
      we_q       <= we_d;
      grant_q    <= grant_d;
      conflict_q <= conflict_d;
      dirty_q    <= dirty_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.we_out     = we_q;
  assign bus.port_grant = grant_q;
  assign bus.conflict   = conflict_q;
  assign bus.dirty      = dirty_q;
  assign bus.wr_cnt     = cnt_q;
endmodule
